// File: rtl/mem_gen_param.sv
// mem_gen_param
// Parametrised single-port synchronous memory model. It supports per-byte
// write masking, a read latency of 1 or 2 cycles with a read-valid strobe,
// and out-of-range address detection. A clear engine zeroes the array after
// reset and whenever clear_req is sampled in READY.
//
// Ports
//   clock      : sole clock, rising edge
//   reset_n    : asynchronous active-low reset
//   chip_en    : access enable; gates rd_en / wr_en
//   wr_en      : write request
//   rd_en      : read request
//   addr       : word address (ADDR_W)
//   wr_data    : write data (DATA_W)
//   wr_mask    : byte write enable, bit i covers wr_data[8i+7:8i]
//   clear_req  : single-cycle request to re-zero the array
//   rd_data    : read data, holds between reads
//   rd_valid   : one-cycle strobe marking new rd_data
//   addr_err   : one-cycle strobe for an accepted access with addr >= DEPTH
//   init_busy  : clear engine active; user accesses are ignored
module mem_gen_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              chip_en,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              clear_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              addr_err,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_word;

  logic [MASK_W-1:0] mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              addr_err_q;

  // Compare with one extra bit so DEPTH == 2**ADDR_W is representable.
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign idx      = addr[IDX_W-1:0];
  assign accept   = (state_q == READY) && chip_en;
  assign rd_fire  = accept && rd_en;
  assign rd_word  = in_range ? mem_q[idx] : '0;

  // Clear engine / FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_busy = (state_q == CLEAR);

  // Single write port shared by the clear engine and user writes.
  always_comb begin
    mem_we    = '0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == CLEAR) begin
      mem_we = '1;
    end else if (accept && wr_en && in_range) begin
      mem_we    = wr_mask;
      mem_waddr = idx;
      mem_wdata = wr_data;
    end
  end

  // Array has no reset; nonblocking update gives read-before-write.
  always_ff @(posedge clock) begin
    for (int unsigned b = 0; b < MASK_W; b++) begin
      if (mem_we[b]) begin
        mem_q[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= accept && (rd_en || wr_en) && !in_range;
    end
  end

  // Read pipeline; in-flight reads drain regardless of FSM state.
  if (RD_LAT == 2) begin : g_lat2
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        s1_valid_q <= rd_fire;
        if (rd_fire) s1_data_q <= rd_word;
        rd_valid_q <= s1_valid_q;
        if (s1_valid_q) rd_data_q <= s1_data_q;
      end
    end
  end else begin : g_lat1
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else begin
        rd_valid_q <= rd_fire;
        if (rd_fire) rd_data_q <= rd_word;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_gen_param.sv
// Testbench for mem_gen_param. Two instances share one stimulus stream:
// instance 0 uses the defaults (DEPTH=1024, RD_LAT=1), instance 1 uses
// DEPTH=1000, RD_LAT=2. A behavioural model tracks each instance and a
// compare process checks every output on every falling edge.
module tb_mem_gen_param;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        chip_en, wr_en, rd_en, clear_req;
  logic [9:0]  addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;

  logic [15:0] o_data  [2];
  logic        o_valid [2];
  logic        o_err   [2];
  logic        o_busy  [2];

  always #5 clock = ~clock;

  mem_gen_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .chip_en(chip_en), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .clear_req(clear_req), .rd_data(o_data[0]), .rd_valid(o_valid[0]),
    .addr_err(o_err[0]), .init_busy(o_busy[0])
  );

  mem_gen_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .chip_en(chip_en), .wr_en(wr_en),
    .rd_en(rd_en), .addr(addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .clear_req(clear_req), .rd_data(o_data[1]), .rd_valid(o_valid[1]),
    .addr_err(o_err[1]), .init_busy(o_busy[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (t=%0t)", name, k, act, exp, $time);
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 1024 : 1000;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  // ---------------- behavioural model ----------------
  // Clearing is modelled as zeroing the whole array at once: while busy the
  // array is unreachable, so only the busy duration is observable.
  typedef struct {
    int          k;
    longint      due;
    logic [15:0] d;
  } rd_t;

  logic [15:0] mm [2][1024];
  rd_t         rq[$];
  logic [15:0] e_data  [2];
  logic        e_valid [2];
  logic        e_err   [2];
  int          busy_left [2];
  longint      cyc = 0;

  task automatic zero_mem(input int k);
    for (int a = 0; a < 1024; a++) mm[k][a] = 16'h0;
  endtask

  task automatic model_reset();
    rq.delete();
    for (int k = 0; k < 2; k++) begin
      e_data[k] = 16'h0; e_valid[k] = 1'b0; e_err[k] = 1'b0;
      busy_left[k] = dep(k);
      zero_mem(k);
    end
  endtask

  task automatic model_edge();
    bit inr;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 1'b0;
      e_err[k]   = 1'b0;
      if (busy_left[k] > 0) begin
        busy_left[k]--;
      end else begin
        if (chip_en) begin
          inr = int'(addr) < dep(k);
          if (rd_en) rq.push_back('{k, cyc + lat(k) - 1, inr ? mm[k][addr] : 16'h0});
          if (wr_en && inr)
            for (int b = 0; b < 2; b++)
              if (wr_mask[b]) mm[k][addr][8*b +: 8] = wr_data[8*b +: 8];
          e_err[k] = (rd_en || wr_en) && !inr;
        end
        if (clear_req) begin
          zero_mem(k);
          busy_left[k] = dep(k);
        end
      end
      for (int i = 0; i < rq.size(); i++) begin
        if (rq[i].k == k && rq[i].due == cyc) begin
          e_valid[k] = 1'b1;
          e_data[k]  = rq[i].d;
          rq.delete(i);
          break;
        end
      end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("rd_valid", k, 32'(o_valid[k]), 32'(e_valid[k]));
        chk("rd_data", k, 32'(o_data[k]), 32'(e_data[k]));
        chk("addr_err", k, 32'(o_err[k]), 32'(e_err[k]));
        chk("init_busy", k, 32'(o_busy[k]), 32'(busy_left[k] != 0));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    chip_en = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
    addr = '0; wr_data = '0; wr_mask = '0;
  endtask

  task automatic set_random(input int clr_div);
    chip_en   = ($urandom_range(0, 9) < 8);
    rd_en     = 1'($urandom_range(0, 1));
    wr_en     = 1'($urandom_range(0, 1));
    addr      = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 15)) : 10'($urandom_range(0, 1023));
    wr_data   = 16'($urandom);
    wr_mask   = 2'($urandom);
    clear_req = ($urandom_range(0, clr_div - 1) == 0);
  endtask

  // One rising edge; returns 1 time unit after it.
  task automatic step();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic acc(input logic r, input logic w, input logic [9:0] a,
                     input logic [15:0] d, input logic [1:0] m, input logic clr);
    chip_en = 1'b1; rd_en = r; wr_en = w; addr = a; wr_data = d; wr_mask = m;
    clear_req = clr;
    step();
    set_idle();
  endtask

  task automatic wait_clear(input string name);
    int n, n0, n1;
    n = 0; n0 = -1; n1 = -1;
    while ((o_busy[0] || o_busy[1]) && n < 3000) begin
      step();
      n++;
      if (!o_busy[0] && n0 < 0) n0 = n;
      if (!o_busy[1] && n1 < 0) n1 = n;
    end
    chk(name, 0, 32'(n0), 32'd1024);
    chk(name, 1, 32'(n1), 32'd1000);
  endtask

  task automatic chk_reset_vals(input string name);
    for (int k = 0; k < 2; k++) begin
      chk({name, "_valid"}, k, 32'(o_valid[k]), 32'd0);
      chk({name, "_data"}, k, 32'(o_data[k]), 32'd0);
      chk({name, "_err"}, k, 32'(o_err[k]), 32'd0);
      chk({name, "_busy"}, k, 32'(o_busy[k]), 32'd1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [5:0] pat0, pat1;
    int n, n1;

    set_idle();
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("por");
    chk_on = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    wait_clear("init_edges");

    // Freshly cleared top address reads zero; out of range on instance 1.
    acc(1, 0, 10'h3FF, 16'h0, 2'b00, 0);
    chk("init_rd_valid", 0, 32'(o_valid[0]), 32'd1);
    chk("init_rd_data", 0, 32'(o_data[0]), 32'h0);
    chk("init_oor_err", 1, 32'(o_err[1]), 32'd1);
    step();
    chk("init_rd_valid", 1, 32'(o_valid[1]), 32'd1);
    chk("init_rd_data", 1, 32'(o_data[1]), 32'h0);

    // Masked write.
    acc(0, 1, 10'd5, 16'hA5C3, 2'b11, 0);
    acc(0, 1, 10'd5, 16'hFF00, 2'b01, 0);
    acc(1, 0, 10'd5, 16'h0, 2'b00, 0);
    chk("mask_rd_data", 0, 32'(o_data[0]), 32'hA500);
    step();
    chk("mask_single_pulse", 0, 32'(o_valid[0]), 32'd0);
    chk("mask_rd_data", 1, 32'(o_data[1]), 32'hA500);

    // Read/write collision returns old data.
    acc(0, 1, 10'd7, 16'h1111, 2'b11, 0);
    acc(1, 1, 10'd7, 16'h2222, 2'b11, 0);
    chk("coll_old", 0, 32'(o_data[0]), 32'h1111);
    chk("coll_lat2_wait", 1, 32'(o_valid[1]), 32'd0);
    step();
    chk("coll_old", 1, 32'(o_data[1]), 32'h1111);
    acc(1, 0, 10'd7, 16'h0, 2'b00, 0);
    step();
    chk("coll_new", 1, 32'(o_data[1]), 32'h2222);

    // Back-to-back reads.
    pat0 = '0; pat1 = '0;
    for (int a = 0; a < 6; a++) begin
      if (a < 4) acc(1, 0, 10'(a), 16'h0, 2'b00, 0);
      else step();
      pat0 = {pat0[4:0], o_valid[0]};
      pat1 = {pat1[4:0], o_valid[1]};
    end
    chk("b2b_pattern", 0, 32'(pat0), 32'b111100);
    chk("b2b_pattern", 1, 32'(pat1), 32'b011110);

    // Out of range on instance 1 (in range on instance 0).
    acc(0, 1, 10'd1010, 16'hDEAD, 2'b11, 0);
    chk("oor_wr_err", 1, 32'(o_err[1]), 32'd1);
    chk("oor_wr_err", 0, 32'(o_err[0]), 32'd0);
    step();
    chk("oor_err_pulse", 1, 32'(o_err[1]), 32'd0);
    acc(1, 1, 10'd1010, 16'h7777, 2'b11, 0);
    chk("oor_rdwr_err", 1, 32'(o_err[1]), 32'd1);
    chk("oor_rd_data", 0, 32'(o_data[0]), 32'hDEAD);
    step();
    chk("oor_rd_valid", 1, 32'(o_valid[1]), 32'd1);
    chk("oor_rd_data", 1, 32'(o_data[1]), 32'h0);
    acc(1, 0, 10'd10, 16'h0, 2'b00, 0);
    step();
    chk("oor_alias_untouched", 1, 32'(o_data[1]), 32'h0);

    // clear_req together with a read.
    for (int a = 0; a < 4; a++) acc(0, 1, 10'(a), 16'hBEEF, 2'b11, 0);
    acc(1, 0, 10'd2, 16'h0, 2'b00, 1);
    chk("clr_inflight", 0, 32'(o_data[0]), 32'hBEEF);
    chk("clr_busy", 0, 32'(o_busy[0]), 32'd1);
    n = 0; n1 = -1;
    while (o_busy[0] && n < 3000) begin
      if (n < 500) set_random(1000000);
      else set_idle();
      step();
      n++;
      if (n == 1) chk("clr_inflight", 1, 32'(o_data[1]), 32'hBEEF);
      if (!o_busy[1] && n1 < 0) n1 = n;
    end
    set_idle();
    chk("clr_edges", 0, 32'(n), 32'd1024);
    chk("clr_edges", 1, 32'(n1), 32'd1000);
    for (int a = 0; a < 4; a++) begin
      acc(1, 0, 10'(a), 16'h0, 2'b00, 0);
      chk("clr_zero", 0, 32'(o_data[0]), 32'h0);
    end
    repeat (2) step();

    // Reset mid-clear at count 300.
    acc(0, 0, 10'd0, 16'h0, 2'b00, 1);
    repeat (300) step();
    reset_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("rst_midclr");
    repeat (3) step();
    reset_n = 1'b1;
    wait_clear("rst_midclr_edges");

    // Reset with a read in flight on instance 1.
    acc(0, 1, 10'd5, 16'h5A5A, 2'b11, 0);
    acc(1, 0, 10'd5, 16'h0, 2'b00, 0);
    chk("rst_pre_data", 0, 32'(o_data[0]), 32'h5A5A);
    reset_n = 1'b0;
    model_reset();
    #1 chk_reset_vals("rst_inflight");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_valid", 1, 32'(o_valid[1]), 32'd0);
    end
    reset_n = 1'b1;
    wait_clear("rst_inflight_edges");

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      set_random(800);
      step();
    end
    set_idle();
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
